// File: rtl/md_scheduler.sv
// rtl/md_scheduler.sv - multiply/divide sequencer owning HI/LO with fixed-latency busy and stall request
module md_scheduler #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_id,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]   hi_r, hi_nxt, lo_r, lo_nxt;
    logic [31:0]   pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
    logic          pend_we, pend_we_nxt;

    logic          is_md_op;
    logic          accept;
    logic [31:0]   res_hi, res_lo;
    logic          res_we;
    logic [CW-1:0] res_lat;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    logic               div_ovf;

    assign is_md_op = (md_op <= 3'd3);
    // A new mult/div may chain into the final busy cycle so there is no dead cycle between operations.
    assign accept   = start && is_md_op &&
                      ((state == IDLE) || (count == CW'(1)));

    always_comb begin
        prod_s  = $signed(a) * $signed(b);
        prod_u  = {32'd0, a} * {32'd0, b};
        div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        quot_s  = 32'sd0;
        rem_s   = 32'sd0;
        quot_u  = 32'd0;
        rem_u   = 32'd0;
        if (b != 32'd0) begin
            quot_u = a / b;
            rem_u  = a % b;
            // The one signed overflow case is resolved explicitly rather than left to the divider.
            if (div_ovf) begin
                quot_s = 32'sh8000_0000;
                rem_s  = 32'sd0;
            end else begin
                quot_s = $signed(a) / $signed(b);
                rem_s  = $signed(a) % $signed(b);
            end
        end
    end

    always_comb begin
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_we  = 1'b1;
        res_lat = CW'(MULT_LAT);
        case (md_op[1:0])
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: begin
                res_hi  = rem_s;
                res_lo  = quot_s;
                res_we  = (b != 32'd0);
                res_lat = CW'(DIV_LAT);
            end
            default: begin
                res_hi  = rem_u;
                res_lo  = quot_u;
                res_we  = (b != 32'd0);
                res_lat = CW'(DIV_LAT);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            hi_r    <= hi_nxt;
            lo_r    <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_we <= pend_we_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        hi_nxt      = hi_r;
        lo_nxt      = lo_r;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_we_nxt = pend_we;
        case (state)
            IDLE: begin
                if (start) begin
                    if (md_op == 3'd4) hi_nxt = a;
                    if (md_op == 3'd5) lo_nxt = a;
                end
            end
            BUSY: begin
                count_nxt = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nxt = IDLE;
                    if (pend_we) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            state_nxt   = BUSY;
            count_nxt   = res_lat;
            pend_hi_nxt = res_hi;
            pend_lo_nxt = res_lo;
            pend_we_nxt = res_we;
        end
    end

    assign busy     = (state == BUSY);
    assign stall_md = md_use_id && (busy || (start && is_md_op));
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule
